// File: rtl/flag_unit.sv
`default_nettype none
// flag_unit: registered N/Z/C/V condition-code unit with a one-cycle registered branch decision.
// Define FLAG_STACK_EN to build the LIFO flag-save stack (push/pop, stk_*).
module flag_unit #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             result,
  input  logic                         carry_in,
  input  logic                         ovf_in,
  input  logic                         flag_we,
  input  logic                         eval,
  input  logic [3:0]                   cond_sel,
  input  logic                         push,
  input  logic                         pop,
  output logic [3:0]                   flags,
  output logic                         take,
  output logic                         take_valid,
  output logic [$clog2(STACK_DEPTH):0] stk_count,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic                         stk_err
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;

  // Flag vector layout is {N, Z, C, V}.
  function automatic logic f_cond(input logic [3:0] sel, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = f;
    res = 1'b0;
    case (sel)
      4'd0:    res = 1'b0;
      4'd1:    res = z;
      4'd2:    res = n;
      4'd3:    res = ~z;
      4'd4:    res = ~n & ~z;
      4'd5:    res = c;
      4'd6:    res = ~c;
      4'd7:    res = 1'b1;
      4'd8:    res = v;
      4'd9:    res = ~v;
      4'd10:   res = n | z;
      4'd11:   res = ~n;
      4'd12:   res = n ^ v;
      4'd13:   res = ~(n ^ v);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [3:0] r_flags;
  logic       r_take;
  logic       r_take_valid;

  logic [3:0] w_new_flags;
  logic [3:0] w_eval_flags;
  logic       w_we_eff;
  logic       w_pop_ok;
  logic [3:0] w_pop_data;

  assign w_new_flags = {result[WIDTH-1], (result == '0), carry_in, ovf_in};

`ifdef FLAG_STACK_EN
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]    r_stack [STACK_DEPTH];
  logic [CW-1:0] r_count;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_push_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_full      = (r_count == CW'(STACK_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_push_ok   = w_push_only & ~w_full;
  assign w_pop_ok    = w_pop_only & ~w_empty;
  assign w_wr_idx    = r_count[AW-1:0];
  assign w_rd_idx    = w_wr_idx - AW'(1);
  assign w_pop_data  = r_stack[w_rd_idx];
  // A pop request (even a rejected one) takes priority over a flag write.
  assign w_we_eff    = flag_we & ~w_pop_only;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[w_wr_idx] <= r_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
      if ((w_push_only & w_full) | (w_pop_only & w_empty)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign stk_count = r_count;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_err   = r_err;
`else
  logic w_unused_stack;

  assign w_unused_stack = push ^ pop;
  assign w_pop_ok       = 1'b0;
  assign w_pop_data     = 4'b0000;
  assign w_we_eff       = flag_we;
  assign stk_count      = '0;
  assign stk_full       = 1'b0;
  assign stk_empty      = 1'b1;
  assign stk_err        = 1'b0;
`endif

  // Same-cycle flag write is forwarded to the condition; a pop cycle sees pre-pop flags.
  assign w_eval_flags = w_we_eff ? w_new_flags : r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags      <= 4'b0000;
      r_take       <= 1'b0;
      r_take_valid <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_flags <= w_pop_data;
      end else if (w_we_eff) begin
        r_flags <= w_new_flags;
      end
      if (eval) begin
        r_take <= f_cond(cond_sel, w_eval_flags);
      end
      r_take_valid <= eval;
    end
  end

  assign flags      = r_flags;
  assign take       = r_take;
  assign take_valid = r_take_valid;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// tb_flag_unit: table-driven check of flag latching/condition evaluation plus stack and reset sequences.
module tb_flag_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] result;
  logic             carry_in, ovf_in, flag_we, eval, push, pop;
  logic [3:0]       cond_sel;
  logic [3:0]       flags;
  logic             take, take_valid;
  logic [CW-1:0]    stk_count;
  logic             stk_full, stk_empty, stk_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .carry_in(carry_in), .ovf_in(ovf_in),
    .flag_we(flag_we), .eval(eval), .cond_sel(cond_sel), .push(push), .pop(pop),
    .flags(flags), .take(take), .take_valid(take_valid), .stk_count(stk_count),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        ev;
    logic [3:0]  cs;
    logic [3:0]  ef;
    logic        et;
    logic        etv;
  } vec_t;

  vec_t vt [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flag_we = 1'b0; eval = 1'b0; push = 1'b0; pop = 1'b0;
    result = '0; carry_in = 1'b0; ovf_in = 1'b0; cond_sel = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // f = {N,Z,C,V}; N and Z must not both be set
  task automatic set_flags(input logic [3:0] f);
    idle();
    flag_we  = 1'b1;
    result   = f[3] ? 32'h8000_0000 : (f[2] ? 32'h0 : 32'h1);
    carry_in = f[1];
    ovf_in   = f[0];
    tick();
    idle();
  endtask

  task automatic chk_stk(input string name, input int cnt, input logic full, input logic empty, input logic err);
    chk({name, "_count"}, 32'(stk_count), 32'(cnt));
    chk({name, "_full"},  32'(stk_full),  32'(full));
    chk({name, "_empty"}, 32'(stk_empty), 32'(empty));
    chk({name, "_err"},   32'(stk_err),   32'(err));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_flags"}, 32'(flags), 32'h0);
    chk({name, "_take"},  32'(take), 32'h0);
    chk({name, "_tv"},    32'(take_valid), 32'h0);
    chk_stk(name, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] fill_vals [4];
    fill_vals = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    //           we    res           c     v     ev    cs     ef       et    etv
    vt[0]  = '{1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0,  4'b0110, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd1,  4'b0110, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd3,  4'b0110, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'd12, 4'b1001, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd2,  4'b1001, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd14, 4'b1001, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd7,  4'b1001, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd15, 4'b1001, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd7,  4'b1001, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0,  4'b1001, 1'b0, 1'b1};
    vt[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd7,  4'b1001, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd7,  4'b1001, 1'b1, 1'b1};
    vt[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0,  4'b1001, 1'b1, 1'b0};
    vt[13] = '{1'b1, 32'h5,        1'b1, 1'b0, 1'b1, 4'd4,  4'b0010, 1'b1, 1'b1};
    vt[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd5,  4'b0010, 1'b1, 1'b1};
    vt[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd6,  4'b0010, 1'b0, 1'b1};
    vt[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd8,  4'b0010, 1'b0, 1'b1};
    vt[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd9,  4'b0010, 1'b1, 1'b1};
    vt[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd10, 4'b0010, 1'b0, 1'b1};
    vt[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd13, 4'b0010, 1'b1, 1'b1};
    vt[20] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd11, 4'b0010, 1'b1, 1'b1};
    vt[21] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd12, 4'b0010, 1'b0, 1'b1};
    vt[22] = '{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 4'd10, 4'b1000, 1'b1, 1'b1};
    vt[23] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd12, 4'b1000, 1'b1, 1'b1};
    vt[24] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd13, 4'b1000, 1'b0, 1'b1};
    vt[25] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd8,  4'b1000, 1'b0, 1'b1};
    vt[26] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd3,  4'b1000, 1'b1, 1'b1};
    vt[27] = '{1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0,  4'b0100, 1'b1, 1'b0};

    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_state("init");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 28; i++) begin
      flag_we = vt[i].we; result = vt[i].res; carry_in = vt[i].c; ovf_in = vt[i].v;
      eval = vt[i].ev; cond_sel = vt[i].cs;
      tick();
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].ef));
      chk($sformatf("vec%0d_take", i), 32'(take), 32'(vt[i].et));
      chk($sformatf("vec%0d_tv", i), 32'(take_valid), 32'(vt[i].etv));
    end
    idle();
    tick();
    chk("tv_drop", 32'(take_valid), 32'h0);

`ifdef FLAG_STACK_EN
    // push saves pre-update flags; pop restores them; eval in pop cycle sees pre-pop flags
    set_flags(4'b1000);
    push = 1'b1; tick(); idle();
    chk("push1_flags", 32'(flags), 32'h8);
    chk_stk("push1", 1, 1'b0, 1'b0, 1'b0);
    set_flags(4'b0100);
    chk("mod_flags", 32'(flags), 32'h4);
    pop = 1'b1; eval = 1'b1; cond_sel = 4'd1; tick(); idle();
    chk("pop1_flags", 32'(flags), 32'h8);
    chk("pop1_take", 32'(take), 32'h1);
    chk_stk("pop1", 0, 1'b0, 1'b1, 1'b0);

    push = 1'b1; tick(); idle();
    pop = 1'b1; flag_we = 1'b1; result = 32'h0; tick(); idle();
    chk("popwe_flags", 32'(flags), 32'h8);
    chk_stk("popwe", 0, 1'b0, 1'b1, 1'b0);

    push = 1'b1; tick(); idle();
    push = 1'b1; pop = 1'b1; flag_we = 1'b1; result = 32'h0; carry_in = 1'b1; tick(); idle();
    chk("pushpop_flags", 32'(flags), 32'h6);
    chk_stk("pushpop", 1, 1'b0, 1'b0, 1'b0);
    pop = 1'b1; tick(); idle();
    chk("pushpop_pop_flags", 32'(flags), 32'h8);

    for (int i = 0; i < DEPTH; i++) begin
      set_flags(fill_vals[i]);
      push = 1'b1; tick(); idle();
    end
    chk_stk("fill", DEPTH, 1'b1, 1'b0, 1'b0);
    set_flags(4'b1001);
    push = 1'b1; tick(); idle();
    chk("ovf_flags", 32'(flags), 32'h9);
    chk_stk("ovf", DEPTH, 1'b1, 1'b0, 1'b1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      pop = 1'b1; tick(); idle();
      chk($sformatf("lifo%0d_flags", i), 32'(flags), 32'(fill_vals[i]));
      chk($sformatf("lifo%0d_count", i), 32'(stk_count), 32'(i));
    end
    pop = 1'b1; tick(); idle();
    chk("unf_flags", 32'(flags), 32'h1);
    chk_stk("unf", 0, 1'b0, 1'b1, 1'b1);

    push = 1'b1; tick(); tick(); idle();
    chk("pre_rst_count", 32'(stk_count), 32'h2);
`else
    push = 1'b1; flag_we = 1'b1; result = 32'h80000000; tick(); idle();
    chk("nostk_push_flags", 32'(flags), 32'h8);
    chk_stk("nostk_push", 0, 1'b0, 1'b1, 1'b0);
    pop = 1'b1; flag_we = 1'b1; result = 32'h0; tick(); idle();
    chk("nostk_pop_flags", 32'(flags), 32'h4);
    chk_stk("nostk_pop", 0, 1'b0, 1'b1, 1'b0);
    push = 1'b1; tick(); tick(); idle();
`endif

    // asynchronous reset in the middle of a cycle
    flag_we = 1'b1; result = 32'h5; carry_in = 1'b1; eval = 1'b1; cond_sel = 4'd7;
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_state("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
